// File: rtl/uart_8250_pkg.sv
// Shared definitions for the 8250-style UART: LCR field layout, transmit
// FSM states, oversampling and stop-length constants, frame helpers.
package uart_8250_pkg;

    // LCR[6:0] bit positions
    localparam int LCR_WLS_LSB = 0;
    localparam int LCR_STB_BIT = 2;
    localparam int LCR_PEN_BIT = 3;
    localparam int LCR_EPS_BIT = 4;
    localparam int LCR_SP_BIT  = 5;
    localparam int LCR_BC_BIT  = 6;

    // Packed view of LCR[6:0], MSB first so a cast from the raw bus lines up
    typedef struct packed {
        logic       bc;
        logic       sp;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int OVERSAMPLE      = 16;
    localparam int STOP_TICKS_1    = 16;
    localparam int STOP_TICKS_1P5  = 24;
    localparam int STOP_TICKS_2    = 32;

    // Stop length in baud ticks; 1.5 stop bits only exist for 5-bit words
    function automatic logic [5:0] stop_ticks(input lcr_t l);
        if (!l.stb)
            return 6'(STOP_TICKS_1);
        else if (l.wls == 2'b00)
            return 6'(STOP_TICKS_1P5);
        else
            return 6'(STOP_TICKS_2);
    endfunction

    // Parity over the low 5+WLS data bits; stick parity sends ~EPS
    function automatic logic parity_bit(input logic [7:0] data, input lcr_t l);
        logic [7:0] mask;
        logic       x;
        case (l.wls)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        x = ^(data & mask);
        if (l.sp)
            return ~l.eps;
        else if (l.eps)
            return x;
        else
            return ~x;
    endfunction

endpackage

// File: rtl/uart_8250_baud_gen.sv
// Baud tick generator: one-cycle pulse every div clocks, restarts its count
// whenever the divisor changes, silent while div is zero.
module uart_8250_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] div_q;

    // Divide-by-div counter with reload on divisor change
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= '0;
            tick  <= 1'b0;
        end else begin
            div_q <= div;
            tick  <= 1'b0;
            if (div != div_q) begin
                cnt_q <= '0;
            end else if (div != 16'd0) begin
                if (cnt_q == div - 16'd1) begin
                    cnt_q <= '0;
                    tick  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_8250_tx.sv
// 8250-style UART transmitter: holding register (or FIFO), frame FSM and a
// registered serial output. Define UART_8250_TX_FIFO_EN to replace the
// single holding register with a FIFO_DEPTH-entry transmit FIFO.
module uart_8250_tx
    import uart_8250_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [15:0] DIV_I,
    input  logic [6:0]  LCR_I,
    input  logic        THR_WE_I,
    input  logic [7:0]  THR_DAT_I,
    output logic        THRE_O,
    output logic        TEMT_O,
    output logic        TXD_O
);

    lcr_t      lcr;
    logic      tick;
    logic      hold_valid;
    logic [7:0] hold_data;
    logic      load;

    tx_state_e state_q, state_d;
    logic [5:0] tick_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [2:0] last_bit_q;
    logic [5:0] stop_len_q;
    logic       pen_q;
    logic       parity_q;
    logic [7:0] shift_q;
    logic       txd_q;
    logic       idle_q;
    logic [5:0] bit_len;
    logic       bit_done;
    logic       line;

    assign lcr = lcr_t'(LCR_I);

    uart_8250_baud_gen u_baud_gen (
        .clk  (CLK_I),
        .rst  (RST_I),
        .div  (DIV_I),
        .tick (tick)
    );

`ifdef UART_8250_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_full;
    logic        push;

    assign hold_valid = (wr_ptr_q != rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = THR_WE_I && !fifo_full;
    assign hold_data  = fifo_mem[rd_ptr_q[AW-1:0]];

    // FIFO pointers; a write while full is dropped
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage
    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge CLK_I) begin
        if (push && !RST_I) fifo_mem[wr_ptr_q[AW-1:0]] <= THR_DAT_I;
    end
`else
    logic hold_valid_q;
    logic unused_fifo_depth;

    // FIFO_DEPTH has no meaning for the single holding register
    assign unused_fifo_depth = (FIFO_DEPTH != 0);
    assign hold_valid        = hold_valid_q;

    // Holding register flag; a new write wins over the shifter load
    always_ff @(posedge CLK_I) begin
        if (RST_I)
            hold_valid_q <= 1'b0;
        else if (THR_WE_I)
            hold_valid_q <= 1'b1;
        else if (load)
            hold_valid_q <= 1'b0;
    end

    // Holding register data; a write while full overwrites the held byte
    always_ff @(posedge CLK_I) begin
        if (THR_WE_I && !RST_I) hold_data <= THR_DAT_I;
    end
`endif

    // State register
    always_ff @(posedge CLK_I) begin
        if (RST_I) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, shifter load request and current line level
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        line     = 1'b1;
        bit_len  = (state_q == ST_STOP) ? stop_len_q : 6'(OVERSAMPLE);
        bit_done = tick && (tick_cnt_q == bit_len - 6'd1);
        case (state_q)
            ST_IDLE: begin
                if (hold_valid) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                line = 1'b0;
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                line = shift_q[0];
                if (bit_done && bit_cnt_q == last_bit_q)
                    state_d = pen_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                line = parity_q;
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (hold_valid) begin
                        state_d = ST_START;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame datapath: latch frame format on load, count ticks and bits, drive TXD
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= '0;
            stop_len_q <= 6'(STOP_TICKS_1);
            pen_q      <= 1'b0;
            parity_q   <= 1'b0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            idle_q     <= 1'b1;
        end else begin
            // Break overrides the line at once but leaves the FSM running
            txd_q  <= lcr.bc ? 1'b0 : line;
            idle_q <= (state_q == ST_IDLE) && (state_d == ST_IDLE);
            if (load) begin
                shift_q    <= hold_data;
                last_bit_q <= {1'b1, lcr.wls};
                stop_len_q <= stop_ticks(lcr);
                pen_q      <= lcr.pen;
                parity_q   <= parity_bit(hold_data, lcr);
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end else if (state_q != ST_IDLE && tick) begin
                if (bit_done) begin
                    tick_cnt_q <= '0;
                    if (state_q == ST_DATA) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        shift_q   <= {1'b0, shift_q[7:1]};
                    end
                end else begin
                    tick_cnt_q <= tick_cnt_q + 6'd1;
                end
            end
        end
    end

    assign TXD_O  = txd_q;
    assign THRE_O = !hold_valid;
    assign TEMT_O = idle_q && !hold_valid;

endmodule

// File: tb/tb_uart_8250_tx.sv
// Directed testbench for uart_8250_tx: frame shapes, parity, stop lengths,
// holding-register overwrite, reset abort and break.
module tb_uart_8250_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div;
    logic [6:0]  lcr;
    logic        thr_we;
    logic [7:0]  thr_dat;
    logic        thre;
    logic        temt;
    logic        txd;

    int errors = 0;
    int checks = 0;

    localparam int WMAX = 1024;
    logic wave_txd  [WMAX];
    logic wave_temt [WMAX];
    logic wave_thre [WMAX];

    uart_8250_tx #(.FIFO_DEPTH(16)) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .DIV_I     (div),
        .LCR_I     (lcr),
        .THR_WE_I  (thr_we),
        .THR_DAT_I (thr_dat),
        .THRE_O    (thre),
        .TEMT_O    (temt),
        .TXD_O     (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        thr_dat = b;
        thr_we  = 1'b1;
        @(negedge clk);
        thr_we  = 1'b0;
    endtask

    // Wait (bounded) for the start-bit falling edge
    task automatic wait_fall(input string tag);
        int n = 0;
        while (txd !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, 32'(txd), 32'd0);
    endtask

    // Record n cycles of outputs, index 0 = first cycle of the start bit
    task automatic record(input string tag, input int n);
        wait_fall(tag);
        for (int i = 0; i < n; i++) begin
            wave_txd[i]  = txd;
            wave_temt[i] = temt;
            wave_thre[i] = thre;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] sample_bits(input int bclk, input int nbits);
        logic [31:0] r = '0;
        for (int k = 0; k < nbits; k++) r[k] = wave_txd[k * bclk + bclk / 2];
        return r;
    endfunction

    function automatic int temt_index();
        for (int i = 0; i < WMAX; i++) if (wave_temt[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int run_len(input int idx, input logic val);
        int n = 0;
        while (idx + n < WMAX && wave_txd[idx + n] === val) n++;
        return n;
    endfunction

    initial begin
        int start_len, ones_len, zeros_len, t;

        rst     = 1'b1;
        div     = 16'd1;
        lcr     = 7'h03;
        thr_we  = 1'b0;
        thr_dat = 8'h00;
        wait_cycles(2);
        check("reset_txd",  32'(txd),  32'd1);
        check("reset_thre", 32'(thre), 32'd1);
        check("reset_temt", 32'(temt), 32'd1);
        rst = 1'b0;
        wait_cycles(4);

        // 8N1, divisor 1, byte 0x55
        write_byte(8'h55);
        check("8n1_thre_after_write", 32'(thre), 32'd0);
        check("8n1_temt_after_write", 32'(temt), 32'd0);
        record("8n1", 200);
        check("8n1_bits",       sample_bits(16, 10), 32'({1'b1, 8'h55, 1'b0}));
        check("8n1_thre_start", 32'(wave_thre[0]), 32'd1);
        check("8n1_start_len",  32'(run_len(0, 1'b0)), 32'd16);
        check("8n1_frame_len",  32'(temt_index()), 32'd160);

        // 8E1, divisor 2, byte 0x07: even parity bit = 1
        div = 16'd2;
        lcr = 7'h1B;
        wait_cycles(8);
        write_byte(8'h07);
        record("8e1", 400);
        check("8e1_bits", sample_bits(32, 11), 32'({1'b1, 1'b1, 8'h07, 1'b0}));
        start_len = run_len(0, 1'b0);
        ones_len  = run_len(start_len, 1'b1);
        zeros_len = run_len(start_len + ones_len, 1'b0);
        check("8e1_ones_run",  32'(ones_len),  32'd96);
        check("8e1_zeros_run", 32'(zeros_len), 32'd160);
        check("8e1_par_stop_len",
              32'(temt_index() - (start_len + ones_len + zeros_len)), 32'd64);

        // 5 data bits with 1.5 stop bits
        div = 16'd1;
        lcr = 7'h04;
        wait_cycles(8);
        write_byte(8'h1F);
        record("5n15", 200);
        check("5n15_bits",      sample_bits(16, 6), 32'h3E);
        check("5n15_frame_len", 32'(temt_index()), 32'd120);

        // 8 data bits with 2 stop bits
        lcr = 7'h07;
        wait_cycles(4);
        write_byte(8'h1F);
        record("8n2", 250);
        check("8n2_bits",      sample_bits(16, 10), 32'({1'b1, 8'h1F, 1'b0}));
        check("8n2_frame_len", 32'(temt_index()), 32'd176);

        // Back-to-back writes A1, B2, C3
        lcr = 7'h03;
        wait_cycles(4);
        thr_we  = 1'b1;
        thr_dat = 8'hA1;
        @(negedge clk);
        thr_dat = 8'hB2;
        @(negedge clk);
        thr_dat = 8'hC3;
        @(negedge clk);
        thr_we  = 1'b0;
        check("b2b_thre_held", 32'(thre), 32'd0);
        record("b2b", 520);
`ifdef UART_8250_TX_FIFO_EN
        check("b2b_bits", sample_bits(16, 30),
              32'({1'b1, 8'hC3, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 8'hA1, 1'b0}));
        check("b2b_temt_rise", 32'(temt_index()), 32'd480);
`else
        check("b2b_bits", sample_bits(16, 20),
              32'({1'b1, 8'hC3, 1'b0, 1'b1, 8'hA1, 1'b0}));
        check("b2b_temt_rise", 32'(temt_index()), 32'd320);
`endif

        // Reset in the middle of DATA, with a write that must be ignored
        write_byte(8'h55);
        wait_fall("rst");
        wait_cycles(40);
        rst     = 1'b1;
        thr_we  = 1'b1;
        thr_dat = 8'h00;
        @(negedge clk);
        check("midrst_txd",  32'(txd),  32'd1);
        check("midrst_thre", 32'(thre), 32'd1);
        check("midrst_temt", 32'(temt), 32'd1);
        rst    = 1'b0;
        thr_we = 1'b0;
        wait_cycles(5);
        check("postrst_temt_idle", 32'(temt), 32'd1);
        check("postrst_txd_idle",  32'(txd),  32'd1);
        write_byte(8'hC3);
        record("postrst", 200);
        check("postrst_bits",      sample_bits(16, 10), 32'({1'b1, 8'hC3, 1'b0}));
        check("postrst_frame_len", 32'(temt_index()), 32'd160);

        // Break mid-frame, then an LCR change that must not alter the frame
        write_byte(8'hFF);
        wait_fall("brk");
        for (int i = 0; i < 200; i++) begin
            wave_txd[i]  = txd;
            wave_temt[i] = temt;
            if (i == 40)  lcr = 7'h43;
            if (i == 70)  lcr = 7'h03;
            if (i == 100) lcr = 7'h00;
            @(negedge clk);
        end
        check("brk_before",    32'(wave_txd[40]),  32'd1);
        check("brk_asserted",  32'(wave_txd[41]),  32'd0);
        check("brk_held",      32'(wave_txd[70]),  32'd0);
        check("brk_released",  32'(wave_txd[71]),  32'd1);
        check("brk_stop_bit",  32'(wave_txd[150]), 32'd1);
        t = temt_index();
        check("brk_frame_len", 32'(t), 32'd160);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
